router_controller: RTL and testbench

//  Sequences a bank of ROUTER_COUNT row routers through a convolution layer, one output window at a time.
//  For each window it performs four steps:
//   - clears router registers;
//   - pulses the address generators;
//   - sweeps the activation SRAM and broadcasts each word to all routers' address comparators;
//   - drains the MISO FIFOs to the PE array in lock-step.

---
 rtl/router_controller_if.sv | 50 +++++
 rtl/router_controller.sv | 242 ++++++++++++++++++++++++
 tb/tb_router_controller.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/router_controller_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : router_controller_if                                            |
// | Purpose  : Handshake/bus bundle between the router controller, the layer   |
// |            scheduler, the router bank and the activation SRAM.             |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface router_controller_if #(
  parameter int ROUTER_COUNT = 4,
  parameter int ADDR_WIDTH   = 8
);
  // scheduler -> controller
  logic                    i_start;
  logic [ADDR_WIDTH-1:0]   i_i_size;
  logic [ADDR_WIDTH-1:0]   i_o_size;
  logic [ADDR_WIDTH-1:0]   i_start_addr;
  logic [ADDR_WIDTH-1:0]   i_end_addr;
  // router bank / PE array -> controller
  logic [ROUTER_COUNT-1:0] i_miso_empty;
  logic                    i_pe_ready;
  // controller -> router bank / SRAM / scheduler
  logic                    o_reg_clear;
  logic                    o_ag_en;
  logic                    o_ac_en;
  logic                    o_sram_re;
  logic [ADDR_WIDTH-1:0]   o_sram_addr;
  logic [ADDR_WIDTH-1:0]   o_o_x;
  logic [ADDR_WIDTH-1:0]   o_o_y;
  logic [ROUTER_COUNT-1:0] o_row_active;
  logic                    o_miso_pop_en;
  logic                    o_busy;
  logic                    o_done;

  // controller side
  modport master (
    input  i_start, i_i_size, i_o_size, i_start_addr, i_end_addr,
    input  i_miso_empty, i_pe_ready,
    output o_reg_clear, o_ag_en, o_ac_en, o_sram_re, o_sram_addr,
    output o_o_x, o_o_y, o_row_active, o_miso_pop_en, o_busy, o_done
  );

  // environment side (scheduler, routers, SRAM)
  modport slave (
    output i_start, i_i_size, i_o_size, i_start_addr, i_end_addr,
    output i_miso_empty, i_pe_ready,
    input  o_reg_clear, o_ag_en, o_ac_en, o_sram_re, o_sram_addr,
    input  o_o_x, o_o_y, o_row_active, o_miso_pop_en, o_busy, o_done
  );
endinterface
`default_nettype wire

// File: rtl/router_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : router_controller                                               |
// | Purpose  : Walks a bank of row routers through a convolution layer one     |
// |            output window at a time: clear, address-gen pulse, SRAM sweep   |
// |            with comparator broadcast, then lock-step MISO drain.           |
// |            Define ROUTER_CTRL_PERF_EN to add busy/stall perf counters.     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module router_controller #(
  parameter int ROUTER_COUNT = 4,
  parameter int ADDR_WIDTH   = 8,
  parameter int KERNEL_SIZE  = 3,
  parameter int AG_LATENCY   = 1,
  parameter int SRAM_LATENCY = 1
) (
  input  wire logic           i_clk,
  input  wire logic           i_rst,
  router_controller_if.master bus
`ifdef ROUTER_CTRL_PERF_EN
  ,
  output logic [31:0]         o_perf_cycles,
  output logic [31:0]         o_perf_stalls
`endif
);

  localparam int YW      = ADDR_WIDTH + 1;
  localparam int POPS    = KERNEL_SIZE * KERNEL_SIZE;
  localparam int POP_W   = $clog2(POPS + 1);
  localparam int LAT_MAX = (AG_LATENCY > SRAM_LATENCY) ? AG_LATENCY : SRAM_LATENCY;
  localparam int LAT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_GEN   = 3'd2,
    ST_READ  = 3'd3,
    ST_TAIL  = 3'd4,
    ST_DRAIN = 3'd5,
    ST_NEXT  = 3'd6,
    ST_DONE  = 3'd7
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   i_size_q, i_size_d;
  logic [ADDR_WIDTH-1:0]   o_size_q, o_size_d;
  logic [ADDR_WIDTH-1:0]   start_addr_q, start_addr_d;
  logic [ADDR_WIDTH-1:0]   end_addr_q, end_addr_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]   o_x_q, o_x_d;
  logic [ADDR_WIDTH-1:0]   o_y_q, o_y_d;
  logic [LAT_W-1:0]        lat_q, lat_d;
  logic [POP_W-1:0]        pop_cnt_q, pop_cnt_d;

  logic [ROUTER_COUNT-1:0] w_row_active;
  logic                    w_pop_ok;
  logic [YW-1:0]           w_y_next;
  logic                    w_reg_clear, w_ag_en, w_ac_en, w_sram_re, w_pop_en, w_done;

  // The input edge is latched for the router bank's benefit but not used here
  logic unused_i_size;
  assign unused_i_size = ^i_size_q;

  // Row k is live while o_y+k is inside the map; extra bit stops wrap at the top
  for (genvar k = 0; k < ROUTER_COUNT; k++) begin : g_row
    assign w_row_active[k] = ({1'b0, o_y_q} + YW'(k)) < {1'b0, o_size_q};
  end

  // A pop needs the PE array ready and every live row holding data
  assign w_pop_ok = bus.i_pe_ready & ~|(bus.i_miso_empty & w_row_active);

  // State and counter register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      i_size_q     <= '0;
      o_size_q     <= '0;
      start_addr_q <= '0;
      end_addr_q   <= '0;
      addr_q       <= '0;
      o_x_q        <= '0;
      o_y_q        <= '0;
      lat_q        <= '0;
      pop_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      i_size_q     <= i_size_d;
      o_size_q     <= o_size_d;
      start_addr_q <= start_addr_d;
      end_addr_q   <= end_addr_d;
      addr_q       <= addr_d;
      o_x_q        <= o_x_d;
      o_y_q        <= o_y_d;
      lat_q        <= lat_d;
      pop_cnt_q    <= pop_cnt_d;
    end
  end

  // Next-state, window stepping and strobe decode
  always_comb begin
    state_d      = state_q;
    i_size_d     = i_size_q;
    o_size_d     = o_size_q;
    start_addr_d = start_addr_q;
    end_addr_d   = end_addr_q;
    addr_d       = addr_q;
    o_x_d        = o_x_q;
    o_y_d        = o_y_q;
    lat_d        = lat_q;
    pop_cnt_d    = pop_cnt_q;
    w_y_next     = {1'b0, o_y_q};
    w_reg_clear  = 1'b0;
    w_ag_en      = 1'b0;
    w_ac_en      = 1'b0;
    w_sram_re    = 1'b0;
    w_pop_en     = 1'b0;
    w_done       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          i_size_d     = bus.i_i_size;
          o_size_d     = bus.i_o_size;
          start_addr_d = bus.i_start_addr;
          end_addr_d   = bus.i_end_addr;
          o_x_d        = '0;
          o_y_d        = '0;
          state_d      = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        w_reg_clear = 1'b1;
        lat_d       = '0;
        state_d     = ST_GEN;
      end
      ST_GEN: begin
        w_ag_en = 1'b1;
        if (lat_q == LAT_W'(AG_LATENCY - 1)) begin
          lat_d   = '0;
          addr_d  = start_addr_q;
          state_d = ST_READ;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      ST_READ: begin
        w_sram_re = 1'b1;
        w_ac_en   = 1'b1;
        if (addr_q == end_addr_q) begin
          lat_d   = '0;
          state_d = ST_TAIL;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      ST_TAIL: begin
        w_ac_en = 1'b1;
        if (lat_q == LAT_W'(SRAM_LATENCY - 1)) begin
          lat_d     = '0;
          pop_cnt_d = '0;
          state_d   = ST_DRAIN;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        w_pop_en = w_pop_ok;
        if (w_pop_ok) begin
          if (pop_cnt_q == POP_W'(POPS - 1)) begin
            pop_cnt_d = '0;
            state_d   = ST_NEXT;
          end else begin
            pop_cnt_d = pop_cnt_q + 1'b1;
          end
        end
      end
      ST_NEXT: begin
        if (o_x_q == o_size_q - 1'b1) begin
          o_x_d    = '0;
          w_y_next = {1'b0, o_y_q} + YW'(ROUTER_COUNT);
        end else begin
          o_x_d = o_x_q + 1'b1;
        end
        o_y_d   = w_y_next[ADDR_WIDTH-1:0];
        state_d = (w_y_next >= {1'b0, o_size_q}) ? ST_DONE : ST_CLEAR;
      end
      ST_DONE: begin
        w_done  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.o_reg_clear   = w_reg_clear;
  assign bus.o_ag_en       = w_ag_en;
  assign bus.o_ac_en       = w_ac_en;
  assign bus.o_sram_re     = w_sram_re;
  assign bus.o_sram_addr   = addr_q;
  assign bus.o_o_x         = o_x_q;
  assign bus.o_o_y         = o_y_q;
  assign bus.o_row_active  = w_row_active;
  assign bus.o_miso_pop_en = w_pop_en;
  assign bus.o_busy        = (state_q != ST_IDLE);
  assign bus.o_done        = w_done;

`ifdef ROUTER_CTRL_PERF_EN
  logic [31:0] perf_cycles_q, perf_cycles_d;
  logic [31:0] perf_stalls_q, perf_stalls_d;

  // Saturating busy-cycle and drain-stall counters, cleared on an accepted start
  always_comb begin
    perf_cycles_d = perf_cycles_q;
    perf_stalls_d = perf_stalls_q;
    if (state_q == ST_IDLE && bus.i_start) begin
      perf_cycles_d = '0;
      perf_stalls_d = '0;
    end else begin
      if (state_q != ST_IDLE && perf_cycles_q != '1)
        perf_cycles_d = perf_cycles_q + 1'b1;
      if (state_q == ST_DRAIN && !w_pop_ok && perf_stalls_q != '1)
        perf_stalls_d = perf_stalls_q + 1'b1;
    end
  end

  // Perf counter register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      perf_cycles_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      perf_cycles_q <= perf_cycles_d;
      perf_stalls_q <= perf_stalls_d;
    end
  end

  assign o_perf_cycles = perf_cycles_q;
  assign o_perf_stalls = perf_stalls_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_router_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_router_controller                                            |
// | Purpose  : Self-checking bench for router_controller. A window-by-window   |
// |            model of the layer walk predicts every cycle's strobes.         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_router_controller;
  localparam int RC  = 4;
  localparam int AW  = 8;
  localparam int K   = 3;
  localparam int AGL = 1;
  localparam int SRL = 1;

  // strobe vector {clear, ag, ac, re, pop, busy, done}
  localparam logic [6:0] S_IDLE = 7'b0000000;
  localparam logic [6:0] S_CLR  = 7'b1000010;
  localparam logic [6:0] S_GEN  = 7'b0100010;
  localparam logic [6:0] S_READ = 7'b0011010;
  localparam logic [6:0] S_TAIL = 7'b0010010;
  localparam logic [6:0] S_NEXT = 7'b0000010;
  localparam logic [6:0] S_DONE = 7'b0000011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  router_controller_if #(.ROUTER_COUNT(RC), .ADDR_WIDTH(AW)) bus ();

`ifdef ROUTER_CTRL_PERF_EN
  logic [31:0] perf_cycles, perf_stalls;
`endif

  router_controller #(
    .ROUTER_COUNT(RC), .ADDR_WIDTH(AW), .KERNEL_SIZE(K),
    .AG_LATENCY(AGL), .SRAM_LATENCY(SRL)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus)
`ifdef ROUTER_CTRL_PERF_EN
    ,
    .o_perf_cycles(perf_cycles),
    .o_perf_stalls(perf_stalls)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] strobes();
    return {bus.o_reg_clear, bus.o_ag_en, bus.o_ac_en, bus.o_sram_re,
            bus.o_miso_pop_en, bus.o_busy, bus.o_done};
  endfunction

  // Row k is live when its output row index lies inside the map
  function automatic logic [RC-1:0] live_rows(input int y, input int osz);
    logic [RC-1:0] r;
    for (int k = 0; k < RC; k++) r[k] = ((y + k) < osz);
    return r;
  endfunction

  // Runs one layer from IDLE; called just after a falling edge.
  // mode 0: always ready; 1: random ready/empties; 2: ready toggling 0,1 plus
  // a stray start pulse; 3: row-2 FIFO empty for the first four drain cycles.
  task automatic run_layer(input int osz, input int sa, input int ea, input int mode);
    int            dc, pops;
    logic [RC-1:0] act;
    logic          rdy, ep;
    logic [RC-1:0] emp;
    bus.i_start      = 1'b1;
    bus.i_i_size     = AW'(osz + 2);
    bus.i_o_size     = AW'(osz);
    bus.i_start_addr = AW'(sa);
    bus.i_end_addr   = AW'(ea);
    bus.i_pe_ready   = 1'b1;
    bus.i_miso_empty = '0;
    #1 chk("idle_before_start", 32'(strobes()), 32'(S_IDLE));
    @(negedge clk);
    // inputs change after acceptance; the layer must keep its latched copies
    bus.i_start      = 1'b0;
    bus.i_o_size     = AW'($urandom);
    bus.i_start_addr = AW'($urandom);
    bus.i_end_addr   = AW'($urandom);
    for (int y = 0; y < osz; y += RC) begin
      for (int x = 0; x < osz; x++) begin
        act = live_rows(y, osz);
        #1;
        chk("clear", 32'(strobes()), 32'(S_CLR));
        chk("win_x", 32'(bus.o_o_x), 32'(x));
        chk("win_y", 32'(bus.o_o_y), 32'(y));
        chk("row_active", 32'(bus.o_row_active), 32'(act));
        @(negedge clk);
        repeat (AGL) begin
          #1 chk("gen", 32'(strobes()), 32'(S_GEN));
          @(negedge clk);
        end
        for (int a = sa; a <= ea; a++) begin
          #1;
          chk("read", 32'(strobes()), 32'(S_READ));
          chk("read_addr", 32'(bus.o_sram_addr), 32'(a));
          @(negedge clk);
        end
        repeat (SRL) begin
          #1 chk("tail", 32'(strobes()), 32'(S_TAIL));
          @(negedge clk);
        end
        dc   = 0;
        pops = 0;
        while (pops < K * K) begin
          rdy = 1'b1;
          emp = '0;
          if (mode == 1 && dc < 150) begin
            rdy = ($urandom_range(0, 3) != 0);
            emp = ($urandom_range(0, 2) == 0) ? RC'($urandom) : '0;
          end else if (mode == 2) begin
            rdy = (dc % 2 == 1);
            if (dc == 3) bus.i_start = 1'b1;
          end else if (mode == 3) begin
            emp = (dc < 4) ? RC'(4'b0100) : '0;
          end
          bus.i_pe_ready   = rdy;
          bus.i_miso_empty = emp;
          #1;
          ep = rdy && ((emp & act) == '0);
          chk("drain_pop", 32'(strobes()), 32'({4'b0000, ep, 2'b10}));
          if (ep) pops++;
          dc++;
          @(negedge clk);
          bus.i_start = 1'b0;
        end
        bus.i_pe_ready   = 1'b1;
        bus.i_miso_empty = '0;
        #1 chk("next", 32'(strobes()), 32'(S_NEXT));
        @(negedge clk);
      end
    end
    #1 chk("done", 32'(strobes()), 32'(S_DONE));
    @(negedge clk);
    #1 chk("idle_after_done", 32'(strobes()), 32'(S_IDLE));
  endtask

  initial begin
    int osz, sa;
    bus.i_start      = 1'b0;
    bus.i_i_size     = '0;
    bus.i_o_size     = '0;
    bus.i_start_addr = '0;
    bus.i_end_addr   = '0;
    bus.i_miso_empty = '0;
    bus.i_pe_ready   = 1'b1;
    rst              = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset_strobes", 32'(strobes()), 32'(S_IDLE));
    chk("reset_addr", 32'(bus.o_sram_addr), 32'd0);
    chk("reset_x", 32'(bus.o_o_x), 32'd0);
    chk("reset_y", 32'(bus.o_o_y), 32'd0);
    chk("reset_rows", 32'(bus.o_row_active), 32'd0);
`ifdef ROUTER_CTRL_PERF_EN
    chk("reset_perf_cycles", perf_cycles, 32'd0);
    chk("reset_perf_stalls", perf_stalls, 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    run_layer(1, 0, 24, 0);     // single window, 25 reads
    run_layer(3, 5, 9, 0);      // three windows on one row band
    run_layer(6, 10, 12, 0);    // row wrap to y=4 with two live rows
    run_layer(3, 0, 2, 3);      // row 2 live: empty flag stalls
    run_layer(2, 0, 2, 3);      // row 2 dead: no stall
    run_layer(2, 1, 3, 2);      // back-pressure plus ignored start
    run_layer(1, 7, 7, 0);      // one-word sweep
    repeat (3) begin
      osz = int'($urandom_range(1, 5));
      sa  = int'($urandom_range(0, 200));
      run_layer(osz, sa, sa + int'($urandom_range(0, 5)), 1);
    end

    // abort mid-READ with asynchronous reset
    bus.i_start      = 1'b1;
    bus.i_o_size     = AW'(2);
    bus.i_start_addr = AW'(0);
    bus.i_end_addr   = AW'(20);
    @(negedge clk);
    bus.i_start = 1'b0;
    repeat (1 + AGL + 3) @(negedge clk);
    #1 chk("pre_abort_read", 32'(strobes()), 32'(S_READ));
    rst = 1'b1;
    #1;
    chk("abort_strobes", 32'(strobes()), 32'(S_IDLE));
    chk("abort_addr", 32'(bus.o_sram_addr), 32'd0);
    chk("abort_rows", 32'(bus.o_row_active), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      #1 chk("abort_no_done", 32'(strobes()), 32'(S_IDLE));
      @(negedge clk);
    end
    run_layer(1, 0, 0, 0);      // recovers cleanly after abort

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // hard stop in case the bench itself loses its way
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
